// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational receiver ALU: decodes instruction words,
// reads an 8x16 register file with stage-2 forwarding, issues to the ALU and retires results/branches.
module alu_issue_ctrl #(
  parameter int unsigned  N       = 16,
  parameter int unsigned  O       = 8,
  parameter int unsigned  S       = 5,
  parameter int unsigned  NREG    = 8,
  parameter logic [O-1:0] OP_NOP  = O'(8'h00),
  parameter logic [O-1:0] OP_BEZ  = O'(8'h20),
  parameter logic [O-1:0] OP_BNEZ = O'(8'h21)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  output logic [O-1:0] alu_opcode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [N-1:0] alu_c,
  output logic [S-1:0] alu_shift,
  input  logic [N-1:0] alu_out,
  output logic         wb_valid,
  output logic [2:0]   wb_addr,
  output logic [N-1:0] wb_data,
  output logic         br_valid,
  output logic [N-1:0] br_target,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  localparam int unsigned IMMW = 15;

  logic [N-1:0] rf [NREG];
  logic         s1_valid;
  logic [2:0]   s1_rd;

  // instruction decode
  logic [O-1:0] d_op;
  logic [2:0]   d_rd, d_ra, d_rb, d_rc;
  logic         d_imm;
  logic         accept_c;
  logic         unused_bits;

  assign d_op     = O'(instr[31:24]);
  assign d_rd     = instr[23:21];
  assign d_ra     = instr[20:18];
  assign d_imm    = instr[15];
  assign d_rb     = instr[14:12];
  assign d_rc     = instr[11:9];
  assign accept_c = instr_valid && instr_ready;
  assign unused_bits = ^{instr[17:16], instr[3:0]};

  // stage-2 register write this cycle (branches and NOP never write)
  logic wr_en_c;
  assign wr_en_c = s1_valid && (alu_opcode != OP_NOP) && (alu_opcode != OP_BEZ)
                   && (alu_opcode != OP_BNEZ) && (s1_rd != 3'd0);

  function automatic logic [N-1:0] read_fwd(input logic [2:0] idx);
    if (idx == 3'd0) return '0;
    if (wr_en_c && (idx == s1_rd)) return alu_out;
    return rf[idx];
  endfunction

  logic [N-1:0] op_a_c, op_b_c, op_c_c;
  logic [S-1:0] op_sh_c;

  assign op_a_c  = read_fwd(d_ra);
  assign op_b_c  = d_imm ? N'($signed(instr[IMMW-1:0])) : read_fwd(d_rb);
  assign op_c_c  = d_imm ? '0 : read_fwd(d_rc);
  assign op_sh_c = d_imm ? '0 : S'(instr[8:4]);

  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

  // issue stage, retire stage and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      instr_ready <= 1'b0;
      alu_opcode  <= OP_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_c       <= '0;
      alu_shift   <= '0;
      s1_valid    <= 1'b0;
      s1_rd       <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      br_valid    <= 1'b0;
      br_target   <= '0;
    end else begin
      // one-cycle flush bubble after a taken branch
      instr_ready <= !br_valid;
      wb_valid    <= 1'b0;
      br_valid    <= 1'b0;

      if (accept_c) begin
        alu_opcode <= d_op;
        alu_a      <= op_a_c;
        alu_b      <= op_b_c;
        alu_c      <= op_c_c;
        alu_shift  <= op_sh_c;
        s1_rd      <= d_rd;
        s1_valid   <= 1'b1;
      end else begin
        alu_opcode <= OP_NOP;
        s1_valid   <= 1'b0;
      end

      if (s1_valid) begin
        if (alu_opcode == OP_BEZ) begin
          if (alu_a == '0) begin
            br_valid  <= 1'b1;
            br_target <= alu_out;
          end
        end else if (alu_opcode == OP_BNEZ) begin
          if (alu_a != '0) begin
            br_valid  <= 1'b1;
            br_target <= alu_out;
          end
        end else if (alu_opcode != OP_NOP) begin
          wb_valid <= 1'b1;
          wb_addr  <= s1_rd;
          wb_data  <= alu_out;
          if (wr_en_c) rf[s1_rd] <= alu_out;
        end
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback controller that feeds the combinational receiver ALU and retires its results. It accepts 32-bit instruction words over a valid/ready handshake, reads operands from an internal 8x16 register file, and drives registered opcode, A, B, C and shift to the ALU. One cycle later it samples the ALU result and writes it back, or reports a branch for BEZ/BNEZ.

Parameters:
N, 16, operand/result width; matches ALU N
O, 8, opcode width
S, 5, shift width
NREG, 8, register-file depth; r0 reads zero, writes to r0 are dropped
OP_NOP, `ALU_NOP, no-writeback opcode
OP_BEZ, `ALU_BEZ, branch-if-zero opcode
OP_BNEZ, `ALU_BNEZ, branch-if-nonzero opcode

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word present
instr_ready  out  1  controller accepts the word this cycle
instr  in  32  instruction word
alu_opcode  out  O  to ALU opcode
alu_a  out  N  to ALU A
alu_b  out  N  to ALU B
alu_c  out  N  to ALU C
alu_shift  out  S  to ALU shift
alu_out  in  N  from ALU out (combinational from the ports above)
wb_valid  out  1  one-cycle pulse: register written this cycle
wb_addr  out  3  register written
wb_data  out  N  value written
br_valid  out  1  one-cycle pulse: branch taken
br_target  out  N  branch target (ALU result)
dbg_addr  in  3  debug register-file read address
dbg_data  out  N  combinational read of regfile[dbg_addr]; r0 returns 0

Behaviour:
- Instruction format: [31:24] opcode, [23:21] rd, [20:18] ra, [17:16] reserved (ignored), [15] imm_sel, [14:0] payload.
- imm_sel=0: rb=[14:12], rc=[11:9], shift=[8:4], [3:0] ignored. A=R[ra], B=R[rb], C=R[rc].
- imm_sel=1: A=R[ra], B=sign-extend([14:0]) to N bits, C=0, shift=0.
- Accept occurs when instr_valid && instr_ready.
- Stage 1 (issue), on accept: register opcode, A, B, C and shift onto the alu_* outputs; latch rd and an s1_valid flag.
- Without an accept, alu_opcode is forced to OP_NOP and s1_valid is 0. The other alu_* outputs hold their values.
- Stage 2 (retire), the cycle after issue with s1_valid=1: sample alu_out.
  - OP_NOP: no effect.
  - OP_BEZ: br_valid=1 and br_target=alu_out if the issued A==0; otherwise nothing.
  - OP_BNEZ: br_valid=1 and br_target=alu_out if the issued A!=0; otherwise nothing.
  - A not-taken branch produces no output. The ALU's X result is never sampled.
  - All other opcodes: R[rd]<=alu_out, wb_valid=1, wb_addr=rd, wb_data=alu_out. With rd=0, wb_valid still pulses but R0 stays 0.
- Issue-to-writeback latency: accept at edge k drives ALU ports after edge k; writeback is registered at edge k+1. Throughput is 1 instruction/cycle.
- Forwarding: if a stage-2 write to rd!=0 coincides with a stage-1 accept that reads the same register (ra, rb or rc), the issued operand takes alu_out, not the stale register. All three operands are checked independently.
- instr_ready=1, except it is 0 for exactly one cycle immediately after the br_valid pulse. This is the flush bubble: a word presented then is held off, not dropped.
- Reset (rst_n=0, any time, asynchronous):
  - all registers cleared to 0;
  - alu_opcode=OP_NOP and alu_a/b/c/shift=0;
  - s1_valid, wb_valid and br_valid=0; wb_addr/wb_data/br_target=0;
  - instr_ready=0 while rst_n=0, and 1 from the first edge after release.
- Reset mid-operation discards the in-flight stage-1 instruction; no writeback or branch follows release.
- Width: ALU result taken as N bits verbatim; no extension or saturation in this block.

Test Plan:
- Reset, then imm ADD_I rd=1 ra=0 imm=0x0005 -> alu_b=0x0005; next cycle wb_valid=1, wb_addr=1, wb_data=alu_out; dbg_addr=1 reads that value.
- Back-to-back: write R1=0x0003, then immediately ADD_I rd=2 ra=1 imm=0x0004 -> alu_a=0x0003 via forwarding; R2=0x0007.
- Imm sign-extend: imm field 0x7FFF -> alu_b=0xFFFF; imm field 0x3FFF -> alu_b=0x3FFF.
- BEZ with R[ra]=0, rb value 0x0040 -> br_valid pulse with br_target=0x0040, no wb_valid; instr_ready=0 the following cycle, and the held word is accepted one cycle later.
- BNEZ with R[ra]=0 -> no br_valid, no wb_valid, instr_ready stays 1. Write with rd=0 -> wb_valid pulses, dbg read of r0 returns 0.
- Assert rst_n low between accept and retire -> no wb_valid/br_valid after release; alu_opcode=OP_NOP; all regs read 0.
